// File: rtl/axil_pkg.sv
// Shared AXI-Lite widths, response codes and the regfile FSM state types.
package axil_pkg;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wr_state_e;
    typedef enum logic { R_IDLE, R_DATA } rd_state_e;
endpackage

// File: rtl/axil_regfile_decode.sv
// Combinational byte address -> register index / in-range decode.
module axil_regfile_decode
    import axil_pkg::*;
#(
    parameter int                        NUM_REGS  = 16,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    output logic [7:0]                index,
    output logic                      in_range
);
    // BASE_ADDR is word aligned, so the low two offset bits never borrow into the index.
    always_comb begin
        index    = addr[9:2] - BASE_ADDR[9:2];
        in_range = (addr >= BASE_ADDR) && (32'(index) < NUM_REGS);
    end
endmodule

// File: rtl/axil_slave_regfile.sv
// AXI-Lite register bank with independent read/write FSMs and parallel register export.
module axil_slave_regfile
    import axil_pkg::*;
#(
    parameter int                        NUM_REGS  = 16,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    output logic [1:0]                s_axil_bresp,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
    output logic [AXI_DATA_WIDTH-1:0] reg_q [NUM_REGS]
);
    logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [AXI_DATA_WIDTH-1:0] regs_d [NUM_REGS];

    wr_state_e                 wstate_q, wstate_d;
    logic                      aw_got_q, aw_got_d;
    logic                      w_got_q, w_got_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [AXI_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [1:0]                bresp_q, bresp_d;

    rd_state_e                 rstate_q, rstate_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;

    logic                      aw_hs, w_hs, ar_hs;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_DATA_WIDTH-1:0] wr_data;
    logic [AXI_STRB_WIDTH-1:0] wr_strb;
    logic [7:0]                wr_idx, rd_idx;
    logic                      wr_ok, rd_ok;

    axil_regfile_decode #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)) u_wr_dec (
        .addr     (wr_addr),
        .index    (wr_idx),
        .in_range (wr_ok)
    );

    axil_regfile_decode #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)) u_rd_dec (
        .addr     (s_axil_araddr),
        .index    (rd_idx),
        .in_range (rd_ok)
    );

    assign s_axil_awready = (wstate_q == W_IDLE) && !aw_got_q;
    assign s_axil_wready  = (wstate_q == W_IDLE) && !w_got_q;
    assign s_axil_bvalid  = (wstate_q == W_RESP);
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = (rstate_q == R_IDLE);
    assign s_axil_rvalid  = (rstate_q == R_DATA);
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign reg_q          = regs_q;

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid && s_axil_wready;
    assign ar_hs = s_axil_arvalid && s_axil_arready;

    // A beat arriving on the completing edge bypasses its holding register.
    assign wr_addr = aw_hs ? s_axil_awaddr : awaddr_q;
    assign wr_data = w_hs  ? s_axil_wdata  : wdata_q;
    assign wr_strb = w_hs  ? s_axil_wstrb  : wstrb_q;

    always_comb begin
        wstate_d = wstate_q;
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        regs_d   = regs_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    awaddr_d = s_axil_awaddr;
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    wdata_d = s_axil_wdata;
                    wstrb_d = s_axil_wstrb;
                end
                if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
                    wstate_d = W_RESP;
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (wr_ok && wr_idx == 8'(i)) begin
                            for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
                                if (wr_strb[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
                            end
                        end
                    end
                end
            end
            W_RESP: begin
                if (s_axil_bready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rstate_d = R_DATA;
                    rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    rdata_d  = '0;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (rd_ok && rd_idx == 8'(i)) rdata_d = regs_q[i];
                    end
                end
            end
            R_DATA: begin
                if (s_axil_rready) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate_q <= W_IDLE;
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
            rstate_q <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wstate_q <= wstate_d;
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bresp_q  <= bresp_d;
            rstate_q <= rstate_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            regs_q   <= regs_d;
        end
    end
endmodule
